// File: rtl/sensor_alarm_handler_if.sv
// Sensor alarm bus: raw sensor lines and host acknowledge in, latched alarm,
// snapshot code and qualified-event count out.
interface sensor_alarm_handler_if #(
  parameter int CNT_WIDTH = 8
);
  logic [3:0]           sensors;
  logic                 alarm_ack;
  logic                 alarm;
  logic [3:0]           alarm_code;
  logic [CNT_WIDTH-1:0] err_count;

  modport master (
    output sensors, alarm_ack,
    input  alarm, alarm_code, err_count
  );

  modport slave (
    input  sensors, alarm_ack,
    output alarm, alarm_code, err_count
  );
endinterface

// File: rtl/sensor_alarm_handler.sv
// Synchronizes the sensor bus, debounces the derived error and holds a sticky alarm until ack.
// Optional qualified-event counter is built when SENSOR_ERR_COUNT_EN is defined.
module sensor_alarm_handler #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_WIDTH       = 8
) (
  input  logic                   clk,
  input  logic                   n_rst,
  sensor_alarm_handler_if.slave  bus
);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    QUALIFY    = 2'd1,
    ALARM      = 2'd2,
    WAIT_CLEAR = 2'd3
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [3:0]    sync1_reg, sens_s;
  logic          alarm_reg;
  logic [3:0]    alarm_code_reg;
  logic          error_s;
  logic          alarm_event;

  assign error_s = sens_s[0] | (sens_s[1] & sens_s[2]) | (sens_s[1] & sens_s[3]);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_reg      <= 4'h0;
      sens_s         <= 4'h0;
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      alarm_reg      <= 1'b0;
      alarm_code_reg <= 4'h0;
    end else begin
      sync1_reg <= bus.sensors;
      sens_s    <= sync1_reg;
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      alarm_reg <= (state_next == ALARM);
      if (alarm_event) begin
        alarm_code_reg <= sens_s;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    alarm_event = 1'b0;
    case (state_reg)
      IDLE: begin
        if (error_s) begin
          state_next = QUALIFY;
          cnt_next   = CW'(1);
        end
      end
      QUALIFY: begin
        // Any dropout restarts qualification from scratch.
        if (!error_s) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next  = ALARM;
          cnt_next    = '0;
          alarm_event = 1'b1;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      ALARM: begin
        if (bus.alarm_ack) begin
          state_next = WAIT_CLEAR;
        end
      end
      WAIT_CLEAR: begin
        // A persisting fault must clear before it can alarm again.
        if (!error_s) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign bus.alarm      = alarm_reg;
  assign bus.alarm_code = alarm_code_reg;

`ifdef SENSOR_ERR_COUNT_EN
  logic [CNT_WIDTH-1:0] err_count_reg;

  // Saturating count; only reset clears it.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      err_count_reg <= '0;
    end else if (alarm_event && (err_count_reg != {CNT_WIDTH{1'b1}})) begin
      err_count_reg <= err_count_reg + CNT_WIDTH'(1);
    end
  end

  assign bus.err_count = err_count_reg;
`else
  assign bus.err_count = '0;
`endif

endmodule

// File: tb/tb_sensor_alarm_handler.sv
// Directed and randomized checks of sensor_alarm_handler against a run-length reference model.
module tb_sensor_alarm_handler;
  localparam int DEB = 4;
  localparam int CW  = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   compared = 0;
  int   mismatched = 0;

  // Reference model state
  logic [3:0] m_s1, m_ss, m_code;
  bit         m_alarm, m_block;
  int         m_run, m_count;

  sensor_alarm_handler_if #(.CNT_WIDTH(CW)) bus ();

  sensor_alarm_handler #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic errf(logic [3:0] s);
    return s[0] | (s[1] & s[2]) | (s[1] & s[3]);
  endfunction

  function automatic int exp_count();
`ifdef SENSOR_ERR_COUNT_EN
    return (m_count > CMAX) ? CMAX : m_count;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    compared++;
    assert (obs === expv)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".alarm"}, {7'd0, bus.alarm}, {7'd0, m_alarm});
    chk({tag, ".code"}, {4'd0, bus.alarm_code}, {4'd0, m_code});
    chk({tag, ".count"}, 8'(bus.err_count), 8'(exp_count()));
  endtask

  task automatic model_reset();
    m_s1 = 4'h0; m_ss = 4'h0; m_code = 4'h0;
    m_alarm = 1'b0; m_block = 1'b0; m_run = 0; m_count = 0;
  endtask

  // One clock: drive inputs, advance the model across the edge, compare after it.
  task automatic step(input logic [3:0] s, input logic a, input string tag);
    logic e;
    bus.sensors = s;
    bus.alarm_ack = a;
    @(posedge clk);
    e = errf(m_ss);
    if (m_alarm) begin
      if (a) begin
        m_alarm = 1'b0;
        m_block = 1'b1;
        $display("ack: code=%h events=%0d", m_code, m_count);
      end
    end else if (m_block) begin
      if (!e) m_block = 1'b0;
    end else if (e) begin
      m_run++;
      if (m_run == DEB) begin
        m_alarm = 1'b1;
        m_code = m_ss;
        m_count++;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    m_ss = m_s1;
    m_s1 = s;
    #1;
    check_model(tag);
  endtask

  task automatic apply_reset(input string tag);
    #2;
    n_rst = 1'b0;
    #1;
    chk({tag, ".rst_alarm"}, {7'd0, bus.alarm}, 8'd0);
    chk({tag, ".rst_code"}, {4'd0, bus.alarm_code}, 8'd0);
    chk({tag, ".rst_count"}, 8'(bus.err_count), 8'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
  endtask

  initial begin
    int len;
    logic [3:0] v;
    int exp6 [5];
    model_reset();
    bus.sensors = 4'hF;
    bus.alarm_ack = 1'b0;

    // 1: reset with all sensors high
    repeat (3) @(posedge clk);
    #1;
    chk("reset.alarm", {7'd0, bus.alarm}, 8'd0);
    chk("reset.code", {4'd0, bus.alarm_code}, 8'd0);
    chk("reset.count", 8'(bus.err_count), 8'd0);
    n_rst = 1'b1;
    repeat (3) step(4'h0, 1'b0, "idle");

    // 2: single sensor fault, alarm after edge 6, ack drops it next edge
    for (int i = 1; i <= 6; i++) begin
      step(4'h1, 1'b0, "t2");
      if (i == 5) chk("t2.edge5", {7'd0, bus.alarm}, 8'd0);
      if (i == 6) chk("t2.edge6", {7'd0, bus.alarm}, 8'd1);
    end
    chk("t2.code", {4'd0, bus.alarm_code}, 8'h01);
    step(4'h1, 1'b0, "t2.sticky");
    step(4'h1, 1'b1, "t2.ack");
    chk("t2.ackdrop", {7'd0, bus.alarm}, 8'd0);
    repeat (4) step(4'h0, 1'b0, "t2.clear");

    // 3: short burst and non-fault pattern
    repeat (3) step(4'b0110, 1'b0, "t3.short");
    repeat (6) step(4'b0000, 1'b0, "t3.gap");
    repeat (10) step(4'b1100, 1'b0, "t3.nofault");
    chk("t3.noalarm", {7'd0, bus.alarm}, 8'd0);

    // Glitch restarts qualification
    repeat (3) step(4'h1, 1'b0, "glitch.a");
    step(4'h0, 1'b0, "glitch.drop");
    repeat (4) step(4'h1, 1'b0, "glitch.b");
    chk("glitch.noalarm", {7'd0, bus.alarm}, 8'd0);
    repeat (4) step(4'h1, 1'b0, "glitch.c");
    step(4'h1, 1'b1, "glitch.ack");
    repeat (4) step(4'h0, 1'b0, "glitch.clear");

    // 4: persisting fault does not re-alarm until it clears
    repeat (8) step(4'b1010, 1'b0, "t4.a");
    chk("t4.alarm", {7'd0, bus.alarm}, 8'd1);
    chk("t4.code", {4'd0, bus.alarm_code}, 8'hA);
    step(4'b1010, 1'b1, "t4.ack");
    repeat (20) step(4'b1010, 1'b0, "t4.hold");
    chk("t4.norealarm", {7'd0, bus.alarm}, 8'd0);
    repeat (4) step(4'h0, 1'b0, "t4.clear");
    repeat (8) step(4'b1010, 1'b0, "t4.b");
    chk("t4.second", {7'd0, bus.alarm}, 8'd1);

    // 5: reset mid-ALARM and mid-QUALIFY
    apply_reset("t5.alarm");
    repeat (3) step(4'h0, 1'b0, "t5.idle");
    repeat (4) step(4'b0011, 1'b0, "t5.qual");
    apply_reset("t5.qual");
    repeat (8) step(4'b0011, 1'b0, "t5.restart");
    chk("t5.code", {4'd0, bus.alarm_code}, 8'h3);

    // 6: saturating event count over five alarm cycles
    apply_reset("t6");
`ifdef SENSOR_ERR_COUNT_EN
    exp6 = '{1, 2, 3, 3, 3};
`else
    exp6 = '{0, 0, 0, 0, 0};
`endif
    for (int k = 0; k < 5; k++) begin
      repeat (7) step(4'h1, 1'b0, "t6.raise");
      chk($sformatf("t6.count%0d", k), 8'(bus.err_count), 8'(exp6[k]));
      step(4'h1, 1'b1, "t6.ack");
      repeat (4) step(4'h0, 1'b0, "t6.clear");
    end

    // Randomized bursts with random acks
    for (int b = 0; b < 60; b++) begin
      v = 4'($urandom_range(0, 15));
      len = $urandom_range(1, 8);
      for (int j = 0; j < len; j++) begin
        step(v, ($urandom_range(0, 3) == 0), "rand");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
